pc_ctrl: RTL and testbench

Program-counter sequencer for the TB4004 core. Owns the 12-bit PC, applies per-instruction PC updates (increment, skip, jump, page-local jump, subroutine call, return), and drives the 8-deep call stack's push/pop interface. It sits between instruction decode, which issues one command per instruction, and the stack. It also detects call-depth overflow and return underflow.

---
 rtl/tb4004_pkg.sv | 39 +++
 rtl/pc_ctrl_if.sv | 21 ++
 rtl/pc_ctrl.sv | 117 +++++++++++
 tb/tb_pc_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tb4004_pkg.sv
// TB4004 shared definitions.
// Command and fault encodings, widths, PC adder.
package tb4004_pkg;

  localparam int PC_W = 12;
  localparam int SP_W = 3;

  typedef enum logic [2:0] {
    CMD_HOLD = 3'd0,
    CMD_INC1 = 3'd1,
    CMD_INC2 = 3'd2,
    CMD_JUN  = 3'd3,
    CMD_JIN  = 3'd4,
    CMD_JMS  = 3'd5,
    CMD_BBL  = 3'd6,
    CMD_RSVD = 3'd7
  } cmd_e;

  typedef enum logic [1:0] {
    FC_NONE = 2'b00,
    FC_OVF  = 2'b01,
    FC_UNF  = 2'b10
  } fcode_e;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_POP_WAIT,
    ST_FAULT
  } state_e;

  // PC increment; wraps mod 4096
  function automatic logic [PC_W-1:0] pc_add(
    input logic [PC_W-1:0] p,
    input logic [1:0]      n
  );
    return p + PC_W'(n);
  endfunction

endpackage

// File: rtl/pc_ctrl_if.sv
// Decode-to-PC-sequencer command handshake.
// master = decode, slave = pc_ctrl.
interface pc_ctrl_if;
  import tb4004_pkg::*;

  logic            cmdValid;
  logic [2:0]      cmd;
  logic [PC_W-1:0] target;
  logic            cmdReady;

  modport master (
    output cmdValid, cmd, target,
    input  cmdReady
  );

  modport slave (
    input  cmdValid, cmd, target,
    output cmdReady
  );

endinterface

// File: rtl/pc_ctrl.sv
// TB4004 program-counter sequencer.
// Owns the PC, drives the call stack, flags over/underflow.
module pc_ctrl
  import tb4004_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 12'h000,
  parameter logic [SP_W-1:0] MAX_SP   = 3'd7
) (
  input  logic            clk,
  input  logic            rstN,
  pc_ctrl_if.slave        cif,
  output logic [PC_W-1:0] pc,
  output logic            stackPush,
  output logic            stackPop,
  output logic [PC_W-1:0] stackPcIn,
  input  logic [SP_W-1:0] stackSp,
  input  logic [PC_W-1:0] stackPcOut,
  input  logic            faultClr,
  output logic            fault,
  output logic [1:0]      faultCode
);

  state_e state;

  logic acc;
  logic isInc1;
  logic isInc2;
  logic isJun;
  logic isJin;
  logic isJms;
  logic isBbl;
  logic spFull;
  logic spEmpty;

  assign cif.cmdReady = rstN & (state == ST_RUN);
  assign acc          = cif.cmdReady & cif.cmdValid;

  assign isInc1 = cif.cmd == CMD_INC1;
  assign isInc2 = cif.cmd == CMD_INC2;
  assign isJun  = cif.cmd == CMD_JUN;
  assign isJin  = cif.cmd == CMD_JIN;
  assign isJms  = cif.cmd == CMD_JMS;
  assign isBbl  = cif.cmd == CMD_BBL;

  assign spFull  = stackSp == MAX_SP;
  assign spEmpty = stackSp == '0;

  assign stackPcIn = pc_add(pc, 2'd2);

  // Stack strobes fire only in the accept cycle of a legal call/return
  always_comb begin
    stackPush = 1'b0;
    stackPop  = 1'b0;
    if (acc) begin
      unique case (1'b1)
        isJms:   stackPush = ~spFull;
        isBbl:   stackPop  = ~spEmpty;
        default: ;
      endcase
    end
  end

  // Sequencer FSM: PC update, pop wait, sticky fault
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      pc        <= RESET_PC;
      fault     <= 1'b0;
      faultCode <= FC_NONE;
      state     <= ST_RUN;
    end else begin
      unique case (state)
        ST_RUN: begin
          if (acc) begin
            unique case (1'b1)
              isInc1: pc <= pc_add(pc, 2'd1);
              isInc2: pc <= pc_add(pc, 2'd2);
              isJun:  pc <= cif.target;
              isJin:  pc <= {pc[PC_W-1:8], cif.target[7:0]};
              isJms: begin
                if (spFull) begin
                  fault     <= 1'b1;
                  faultCode <= FC_OVF;
                  state     <= ST_FAULT;
                end else begin
                  pc <= cif.target;
                end
              end
              isBbl: begin
                if (spEmpty) begin
                  fault     <= 1'b1;
                  faultCode <= FC_UNF;
                  state     <= ST_FAULT;
                end else begin
                  state <= ST_POP_WAIT;
                end
              end
              default: ;
            endcase
          end
        end
        ST_POP_WAIT: begin
          pc    <= stackPcOut;
          state <= ST_RUN;
        end
        ST_FAULT: begin
          if (faultClr) begin
            fault     <= 1'b0;
            faultCode <= FC_NONE;
            state     <= ST_RUN;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_ctrl.sv
// pc_ctrl bench: directed pins plus random traffic
// against a queue-based model, with a behavioural stack.
module tb_pc_ctrl;
  import tb4004_pkg::*;

  localparam logic [11:0] RST_PC = 12'h000;

  logic        clk = 1'b0;
  logic        rstN;
  logic [11:0] pc;
  logic        stackPush;
  logic        stackPop;
  logic [11:0] stackPcIn;
  logic [2:0]  stackSp;
  logic [11:0] stackPcOut;
  logic        faultClr;
  logic        fault;
  logic [1:0]  faultCode;

  pc_ctrl_if cif();

  pc_ctrl #(
    .RESET_PC(RST_PC),
    .MAX_SP  (3'd7)
  ) dut (
    .clk       (clk),
    .rstN      (rstN),
    .cif       (cif),
    .pc        (pc),
    .stackPush (stackPush),
    .stackPop  (stackPop),
    .stackPcIn (stackPcIn),
    .stackSp   (stackSp),
    .stackPcOut(stackPcOut),
    .faultClr  (faultClr),
    .fault     (fault),
    .faultCode (faultCode)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(
    input string       nm,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, got, exp, $time);
    end
  endtask

  // Behavioural 8-entry call stack
  logic [11:0] stk [8];
  logic [2:0]  esp;
  logic [11:0] epop;

  assign stackSp    = esp;
  assign stackPcOut = epop;

  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      esp  <= 3'd0;
      epop <= 12'h000;
    end else if (stackPush) begin
      stk[esp] <= stackPcIn;
      esp      <= esp + 3'd1;
    end else if (stackPop) begin
      epop <= stk[esp - 3'd1];
      esp  <= esp - 3'd1;
    end
  end

  // Reference model: mode 0 run, 1 waiting on pop, 2 faulted
  int m_pc;
  int m_mode;
  int m_fault;
  int m_code;
  int m_ret;
  int q[$];
  int e_rdy;
  int e_acc;
  int e_push;
  int e_pop;
  int c;

  always @(negedge clk) begin
    if (rstN !== 1'b1) begin
      m_pc    = RST_PC;
      m_mode  = 0;
      m_fault = 0;
      m_code  = 0;
      q.delete();
    end
    e_rdy  = (rstN === 1'b1 && m_mode == 0) ? 1 : 0;
    e_acc  = (e_rdy == 1 && cif.cmdValid === 1'b1) ? 1 : 0;
    c      = int'(cif.cmd);
    e_push = (e_acc == 1 && c == 5 && q.size() < 7) ? 1 : 0;
    e_pop  = (e_acc == 1 && c == 6 && q.size() > 0) ? 1 : 0;
    chk("pc", 32'(pc), m_pc);
    chk("cmdReady", 32'(cif.cmdReady), e_rdy);
    chk("stackPush", 32'(stackPush), e_push);
    chk("stackPop", 32'(stackPop), e_pop);
    chk("stackPcIn", 32'(stackPcIn), (m_pc + 2) % 4096);
    chk("fault", 32'(fault), m_fault);
    chk("faultCode", 32'(faultCode), m_code);
    if (rstN === 1'b1) begin
      case (m_mode)
        0: if (e_acc == 1) begin
          case (c)
            1: m_pc = (m_pc + 1) % 4096;
            2: m_pc = (m_pc + 2) % 4096;
            3: m_pc = int'(cif.target);
            4: m_pc = (m_pc / 256) * 256
                    + int'(cif.target) % 256;
            5: if (q.size() < 7) begin
              q.push_back((m_pc + 2) % 4096);
              m_pc = int'(cif.target);
            end else begin
              m_fault = 1;
              m_code  = 1;
              m_mode  = 2;
            end
            6: if (q.size() > 0) begin
              m_ret  = q.pop_back();
              m_mode = 1;
            end else begin
              m_fault = 1;
              m_code  = 2;
              m_mode  = 2;
            end
            default: ;
          endcase
        end
        1: begin
          m_pc   = m_ret;
          m_mode = 0;
        end
        default: if (faultClr === 1'b1) begin
          m_fault = 0;
          m_code  = 0;
          m_mode  = 0;
        end
      endcase
    end
  end

  task automatic drive(
    input bit v,
    input int cm,
    input int t,
    input bit clr
  );
    @(posedge clk);
    #1;
    cif.cmdValid = v;
    cif.cmd      = 3'(cm);
    cif.target   = 12'(t);
    faultClr     = clr;
  endtask

  task automatic idle();
    drive(1'b0, 0, 0, 1'b0);
  endtask

  task automatic cmdo(input int cm, input int t);
    drive(1'b1, cm, t, 1'b0);
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  initial begin
    rstN         = 1'b0;
    cif.cmdValid = 1'b0;
    cif.cmd      = 3'd0;
    cif.target   = 12'h000;
    faultClr     = 1'b0;
    settle();
    chk("rst_ready", 32'(cif.cmdReady), 0);
    chk("rst_pc", 32'(pc), 32'h000);
    @(posedge clk);
    #1;
    rstN = 1'b1;
    settle();
    chk("rel_ready", 32'(cif.cmdReady), 1);
    chk("rel_fault", 32'(fault), 0);

    repeat (3) cmdo(CMD_INC1, 0);
    idle();
    settle();
    chk("inc1x3", 32'(pc), 32'h003);

    cmdo(CMD_JUN, 12'hFFF);
    cmdo(CMD_INC1, 0);
    idle();
    settle();
    chk("wrap1", 32'(pc), 32'h000);
    cmdo(CMD_JUN, 12'hFFF);
    cmdo(CMD_INC2, 0);
    idle();
    settle();
    chk("wrap2", 32'(pc), 32'h001);

    cmdo(CMD_JUN, 12'h123);
    cmdo(CMD_JMS, 12'h456);
    settle();
    chk("jms_push", 32'(stackPush), 1);
    chk("jms_pcin", 32'(stackPcIn), 32'h125);
    idle();
    settle();
    chk("jms_pc", 32'(pc), 32'h456);
    cmdo(CMD_BBL, 0);
    settle();
    chk("bbl_pop", 32'(stackPop), 1);
    idle();
    settle();
    chk("bbl_wait", 32'(cif.cmdReady), 0);
    idle();
    settle();
    chk("bbl_pc", 32'(pc), 32'h125);
    chk("bbl_ready", 32'(cif.cmdReady), 1);

    cmdo(CMD_JUN, 12'h3F0);
    cmdo(CMD_JIN, 12'h927);
    idle();
    settle();
    chk("jin", 32'(pc), 32'h327);
    cmdo(CMD_JUN, 12'hABC);
    idle();
    settle();
    chk("jun", 32'(pc), 32'hABC);

    for (int i = 0; i < 7; i++) cmdo(CMD_JMS, 12'h100 + i);
    cmdo(CMD_JMS, 12'h777);
    settle();
    chk("ovf_nopush", 32'(stackPush), 0);
    idle();
    settle();
    chk("ovf_fault", 32'(fault), 1);
    chk("ovf_code", 32'(faultCode), 32'h1);
    chk("ovf_ready", 32'(cif.cmdReady), 0);
    chk("ovf_pc", 32'(pc), 32'h106);
    drive(1'b0, 0, 0, 1'b1);
    idle();
    settle();
    chk("clr_ready", 32'(cif.cmdReady), 1);
    chk("clr_fault", 32'(fault), 0);

    for (int i = 0; i < 7; i++) begin
      cmdo(CMD_BBL, 0);
      idle();
    end
    cmdo(CMD_BBL, 0);
    settle();
    chk("unf_nopop", 32'(stackPop), 0);
    idle();
    settle();
    chk("unf_fault", 32'(fault), 1);
    chk("unf_code", 32'(faultCode), 32'h2);
    drive(1'b0, 0, 0, 1'b1);
    idle();

    cmdo(CMD_JUN, 12'h555);
    cmdo(CMD_JMS, 12'h200);
    cmdo(CMD_BBL, 0);
    idle();
    rstN = 1'b0;
    settle();
    chk("rstpw_pc", 32'(pc), 32'(RST_PC));
    chk("rstpw_ready", 32'(cif.cmdReady), 0);
    @(posedge clk);
    #1;
    rstN = 1'b1;
    settle();
    chk("rstpw_run", 32'(cif.cmdReady), 1);

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      rstN         = ($urandom % 400) != 0;
      cif.cmdValid = ($urandom % 4) != 0;
      cif.cmd      = 3'($urandom_range(0, 7));
      cif.target   = 12'($urandom);
      faultClr     = ($urandom % 3) == 0;
    end
    rstN = 1'b1;
    idle();
    settle();
    settle();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
